// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM unified memory arbiter.
// Owner and state enums plus byte-lane helpers.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_LANE0 = 4'b0001;

  function automatic logic [3:0] byte_en(
    input logic       byte_acc,
    input logic [1:0] lane
  );
    return byte_acc ? (BE_LANE0 << lane) : BE_WORD;
  endfunction

  function automatic logic [7:0] lane_sel(
    input logic [31:0] word,
    input logic [1:0]  lane
  );
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the unified memory arbiter.
// slave = arbiter view, master = pipeline/memory view.
interface unified_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          if_stall;

  logic          dm_req;
  logic          dm_we;
  logic          dm_byte;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          dm_stall;

  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_valid, if_stall,
    input  dm_req, dm_we, dm_byte, dm_addr, dm_wdata,
    output dm_rdata, dm_valid, dm_stall,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_valid, if_stall,
    output dm_req, dm_we, dm_byte, dm_addr, dm_wdata,
    input  dm_rdata, dm_valid, dm_stall,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/unified_mem_arbiter_fsm.sv
// Grant/latency sequencer: state, latency count, DM run count, drop flag.
// Completion and re-arbitration share one cycle so grants go back-to-back.
module mem_arb_fsm
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int MAX_MEM_RUN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_flush,
  input  logic dm_req,
  output logic grant_if,
  output logic grant_dm,
  output logic if_done,
  output logic dm_done
);

  localparam int LW = $clog2(MEM_LATENCY + 1);
  localparam int RW = $clog2(MAX_MEM_RUN + 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LATENCY);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_MEM_RUN);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [RW-1:0] run_q, run_d;
  logic          drop_q, drop_d;
  logic          arb, complete, if_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      lat_q   <= '0;
      run_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
      run_q   <= run_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    lat_d    = lat_q;
    run_d    = run_q;
    drop_d   = drop_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if_done  = 1'b0;
    dm_done  = 1'b0;
    arb      = 1'b0;
    complete = 1'b0;
    if_ok    = if_req & ~if_flush;

    unique case (state_q)
      ST_IDLE: arb = 1'b1;
      ST_BUSY: begin
        if (lat_q == '0) begin
          complete = 1'b1;
          arb      = 1'b1;
          drop_d   = 1'b0;
        end else begin
          lat_d = lat_q - LW'(1);
          if (owner_q == OWN_IF && if_flush)
            drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      if_done = (owner_q == OWN_IF) & ~drop_q & ~if_flush;
      dm_done = (owner_q == OWN_DM);
    end

    // IF only overrides a pending DM once the DM run hits its cap
    if (arb) begin
      grant_if = if_ok & ((run_q == RUN_MAX) | ~dm_req);
      grant_dm = dm_req & ~grant_if;
      unique case (1'b1)
        grant_if: begin
          state_d = ST_BUSY;
          owner_d = OWN_IF;
          lat_d   = LAT_LOAD;
          run_d   = '0;
          drop_d  = 1'b0;
        end
        grant_dm: begin
          state_d = ST_BUSY;
          owner_d = OWN_DM;
          lat_d   = LAT_LOAD;
          run_d   = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
          drop_d  = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
          run_d   = '0;
          drop_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: IF fetch vs MEM load/store on one memory port.
// Holds the registered command and steers byte lanes both ways.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int MAX_MEM_RUN = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input logic                 clk,
  input logic                 reset,
  unified_mem_arbiter_if.slave bus
);

  logic          grant_if, grant_dm, if_done, dm_done;
  logic          req_q, we_q, st_q, ld_byte_q;
  logic [3:0]    be_q;
  logic [1:0]    lane_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata, dm_rdata;
  logic          dm_stall, if_stall;

  mem_arb_fsm #(
    .MEM_LATENCY (MEM_LATENCY),
    .MAX_MEM_RUN (MAX_MEM_RUN)
  ) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .if_req   (bus.if_req),
    .if_flush (bus.if_flush),
    .dm_req   (bus.dm_req),
    .grant_if (grant_if),
    .grant_dm (grant_dm),
    .if_done  (if_done),
    .dm_done  (dm_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      st_q      <= 1'b0;
      ld_byte_q <= 1'b0;
      lane_q    <= '0;
    end else begin
      req_q   <= grant_if | grant_dm;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      if (grant_dm) begin
        we_q      <= bus.dm_we;
        be_q      <= byte_en(bus.dm_byte, bus.dm_addr[1:0]);
        addr_q    <= {bus.dm_addr[AW-1:2], 2'b00};
        wdata_q   <= bus.dm_byte ? {(DW/8){bus.dm_wdata[7:0]}}
                                 : bus.dm_wdata;
        st_q      <= bus.dm_we;
        ld_byte_q <= bus.dm_byte;
        lane_q    <= bus.dm_addr[1:0];
      end else if (grant_if) begin
        be_q   <= BE_WORD;
        addr_q <= {bus.if_addr[AW-1:2], 2'b00};
      end
    end
  end

  always_comb begin
    if_rdata = '0;
    dm_rdata = '0;
    if (if_done)
      if_rdata = bus.mem_rdata;
    if (dm_done && !st_q)
      dm_rdata = ld_byte_q ? DW'(lane_sel(bus.mem_rdata[31:0], lane_q))
                           : bus.mem_rdata;
  end

  // reset gating keeps every output low while reset is held
  assign dm_stall = ~reset & bus.dm_req & ~dm_done;
  assign if_stall = ~reset & ((bus.if_req & ~if_done) | dm_stall);

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata;
  assign bus.if_valid  = if_done;
  assign bus.if_stall  = if_stall;
  assign bus.dm_rdata  = dm_rdata;
  assign bus.dm_valid  = dm_done;
  assign bus.dm_stall  = dm_stall;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a 2-cycle memory model.
// Vector table for load/store steering plus hand-written corner sequences.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.AW(32), .DW(32)) bus();

  unified_mem_arbiter #(
    .MEM_LATENCY (2),
    .MAX_MEM_RUN (4),
    .AW          (32),
    .DW          (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  bit          written [256];
  logic        p1 = 1'b0, p2 = 1'b0;
  logic [31:0] a1 = '0, a2 = '0;

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    if (idx == 8'd64) return 32'h0;
    if (idx == 8'd73) return 32'h4808_0000;
    return 32'hC0DE_0000 | {22'd0, idx, 2'b00};
  endfunction

  function automatic logic [31:0] rd_word(input logic [7:0] idx);
    return written[idx] ? mem[idx] : init_word(idx);
  endfunction

  always @(posedge clk) begin
    logic [31:0] w;
    p1 <= bus.mem_req;
    a1 <= bus.mem_addr;
    p2 <= p1;
    a2 <= a1;
    if (bus.mem_req && bus.mem_we) begin
      w = rd_word(bus.mem_addr[9:2]);
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
      mem[bus.mem_addr[9:2]] <= w;
      written[bus.mem_addr[9:2]] <= 1'b1;
    end
  end

  always_comb bus.mem_rdata = p2 ? rd_word(a2[9:2]) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // waits for if_valid; drops if_req in the valid cycle
  task automatic wait_if(input int k0, input int lim, output int kk,
                         output logic [31:0] d, output logic stall_ok);
    kk = -1;
    d = '0;
    stall_ok = 1'b1;
    for (int k = k0; k <= lim; k++) begin
      cyc();
      #1;
      if (bus.if_valid) begin
        kk = k;
        d = bus.if_rdata;
        stall_ok = !bus.if_stall;
        bus.if_req = 1'b0;
        break;
      end else if (!bus.if_stall) begin
        stall_ok = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] maddr;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[11];
  logic [31:0] exp_g[7];
  logic [31:0] got_g[7];

  initial begin
    int kk, kd, ng;
    logic [31:0] d, dd;
    logic ok, got, seen;

    vt[0]  = '{1'b1, 1'b1, 32'h103, 32'hAB,       4'h8, 32'hABABABAB, 32'h100, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 32'h103, 32'h0,        4'h8, 32'h0,        32'h100, 32'hAB};
    vt[2]  = '{1'b0, 1'b0, 32'h100, 32'h0,        4'hF, 32'h0,        32'h100, 32'hAB000000};
    vt[3]  = '{1'b1, 1'b1, 32'h101, 32'h1234565C, 4'h2, 32'h5C5C5C5C, 32'h100, 32'h0};
    vt[4]  = '{1'b0, 1'b0, 32'h102, 32'h0,        4'hF, 32'h0,        32'h100, 32'hAB005C00};
    vt[5]  = '{1'b0, 1'b1, 32'h101, 32'h0,        4'h2, 32'h0,        32'h100, 32'h5C};
    vt[6]  = '{1'b1, 1'b0, 32'h104, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 32'h104, 32'h0};
    vt[7]  = '{1'b0, 1'b1, 32'h106, 32'h0,        4'h4, 32'h0,        32'h104, 32'hFE};
    vt[8]  = '{1'b0, 1'b1, 32'h100, 32'h0,        4'h1, 32'h0,        32'h100, 32'h0};
    vt[9]  = '{1'b0, 1'b0, 32'h124, 32'h0,        4'hF, 32'h0,        32'h124, 32'h48080000};
    vt[10] = '{1'b0, 1'b1, 32'h00B, 32'h0,        4'h8, 32'h0,        32'h008, 32'hC0};

    exp_g = '{32'h104, 32'h104, 32'h104, 32'h104, 32'h8, 32'h104, 32'h104};

    reset = 1'b1;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.if_flush = 1'b0;
    bus.dm_req = 1'b0;
    bus.dm_we = 1'b0;
    bus.dm_byte = 1'b0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;

    #1;
    chk("reset_ctl", {bus.mem_req, bus.mem_we, bus.mem_be, bus.if_valid,
                      bus.dm_valid, bus.if_stall, bus.dm_stall}, '0);
    chk("reset_data", {bus.mem_addr, bus.if_rdata ^ bus.dm_rdata}, '0);
    cyc();
    cyc();
    reset = 1'b0;

    // single fetch
    cyc();
    bus.if_req = 1'b1;
    bus.if_addr = 32'd292;
    #1;
    chk("t1_stall0", {bus.if_stall, bus.mem_req}, 2'b10);
    cyc();
    #1;
    chk("t1_cmd", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr},
        {1'b1, 1'b0, 4'hF, 32'd292});
    wait_if(2, 8, kk, d, ok);
    chk("t1_latency", kk, 3);
    chk("t1_rdata", d, 32'h4808_0000);
    chk("t1_stall", ok, 1'b1);

    // load/store steering table
    foreach (vt[i]) begin
      cyc();
      bus.dm_req = 1'b1;
      bus.dm_we = vt[i].we;
      bus.dm_byte = vt[i].byt;
      bus.dm_addr = vt[i].addr;
      bus.dm_wdata = vt[i].wdata;
      #1;
      chk("vec_stall", bus.dm_stall, 1'b1);
      cyc();
      bus.dm_req = 1'b0;
      #1;
      chk("vec_ctl", {bus.mem_req, bus.mem_we, bus.mem_be},
          {1'b1, vt[i].we, vt[i].be});
      chk("vec_addr_wdata", {bus.mem_addr, bus.mem_wdata},
          {vt[i].maddr, vt[i].mwdata});
      got = 1'b0;
      for (int k = 0; k < 5; k++) begin
        cyc();
        #1;
        if (bus.dm_valid) begin
          got = 1'b1;
          chk("vec_latency", k, 1);
          chk("vec_rdata", bus.dm_rdata, vt[i].rdata);
          break;
        end
      end
      if (!got) chk("vec_valid_timeout", 0, 1);
    end

    // simultaneous IF and DM
    cyc();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h8;
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b0;
    bus.dm_byte = 1'b0;
    bus.dm_addr = 32'h104;
    #1;
    chk("t2_stalls", {bus.if_stall, bus.dm_stall}, 2'b11);
    cyc();
    bus.dm_req = 1'b0;
    #1;
    chk("t2_dm_first", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h104});
    kd = -1;
    kk = -1;
    dd = '0;
    d = '0;
    for (int k = 2; k <= 10; k++) begin
      cyc();
      #1;
      if (bus.dm_valid && kd < 0) begin
        kd = k;
        dd = bus.dm_rdata;
      end
      if (bus.if_valid) begin
        kk = k;
        d = bus.if_rdata;
        bus.if_req = 1'b0;
        break;
      end
    end
    chk("t2_dm_cycle", kd, 3);
    chk("t2_dm_rdata", dd, 32'hCAFEF00D);
    chk("t2_if_cycle", kk, 6);
    chk("t2_if_rdata", d, 32'hC0DE0008);

    // DM run cap forces one IF grant
    cyc();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h8;
    bus.dm_req = 1'b1;
    bus.dm_addr = 32'h104;
    ng = 0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.mem_req) begin
        got_g[ng] = bus.mem_addr;
        ng++;
      end
      if (bus.if_valid) begin
        seen = 1'b1;
        chk("t3_if_stall_forced", {bus.if_valid, bus.if_stall, bus.dm_stall},
            3'b111);
      end
      if (ng == 7) break;
      cyc();
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    chk("t3_grant_count", ng, 7);
    chk("t3_if_valid_seen", seen, 1'b1);
    for (int g = 0; g < 7; g++)
      if (g < ng) chk("t3_grant_order", got_g[g], exp_g[g]);
    repeat (5) cyc();

    // flush: blocked in idle, dropped in busy
    cyc();
    bus.if_req = 1'b1;
    bus.if_flush = 1'b1;
    bus.if_addr = 32'h8;
    #1;
    chk("t5_idle_stall", bus.if_stall, 1'b1);
    cyc();
    bus.if_flush = 1'b0;
    #1;
    chk("t5_flush_blocks", bus.mem_req, 1'b0);
    cyc();
    bus.if_flush = 1'b1;
    #1;
    chk("t5_cmd", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h8});
    cyc();
    bus.if_flush = 1'b0;
    bus.if_addr = 32'd232;
    #1;
    chk("t5_no_valid_c2", bus.if_valid, 1'b0);
    cyc();
    #1;
    chk("t5_done_dropped", {bus.if_valid, bus.if_stall, bus.if_rdata},
        {1'b0, 1'b1, 32'h0});
    cyc();
    #1;
    chk("t5_regrant", {bus.mem_req, bus.mem_addr}, {1'b1, 32'd232});
    wait_if(5, 10, kk, d, ok);
    chk("t5_if_cycle", kk, 6);
    chk("t5_if_rdata", d, 32'hC0DE00E8);

    // reset during a DM load
    cyc();
    bus.dm_req = 1'b1;
    bus.dm_we = 1'b0;
    bus.dm_byte = 1'b0;
    bus.dm_addr = 32'h104;
    cyc();
    bus.dm_req = 1'b0;
    #1;
    chk("t6_busy", {bus.mem_req, bus.mem_addr}, {1'b1, 32'h104});
    reset = 1'b1;
    #1;
    chk("t6_async_ctl", {bus.mem_req, bus.mem_we, bus.mem_be, bus.dm_valid,
                         bus.if_valid, bus.dm_stall, bus.if_stall}, '0);
    chk("t6_async_addr", bus.mem_addr, 32'h0);
    cyc();
    cyc();
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      if (bus.dm_valid) seen = 1'b1;
    end
    chk("t6_no_dm_valid", seen, 1'b0);
    cyc();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h124;
    #1;
    wait_if(1, 8, kk, d, ok);
    chk("t6_if_cycle", kk, 3);
    chk("t6_if_rdata", d, 32'h4808_0000);

    repeat (3) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
